// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - state encoding, init command table and row base addresses shared by the LCD message sequencer
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_WAIT_DONE,
        ST_SETTLE,
        ST_ADVANCE
    } seq_state_t;

    localparam int         INIT_STEPS = 4;
    localparam int         TITLE_LEN  = 16;
    localparam logic [7:0] SPACE_CHAR = 8'h20;

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h01;
            default: cmd = 8'h06;
        endcase
        return cmd;
    endfunction

    // Set-DDRAM-address commands for the start of each physical row.
    function automatic logic [7:0] row_addr(input logic [1:0] row);
        logic [7:0] cmd;
        case (row)
            2'd0:    cmd = 8'h80;
            2'd1:    cmd = 8'hC0;
            2'd2:    cmd = 8'h94;
            default: cmd = 8'hD4;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_msg_sequencer_if.sv
// rtl/lcd_msg_sequencer_if.sv - host-side byte handshake between the sequencer and the LCD controller
interface lcd_msg_sequencer_if;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_start;
    logic       lcd_done;

    modport master (
        output lcd_data,
        output lcd_rs,
        output lcd_start,
        input  lcd_done
    );

    modport slave (
        input  lcd_data,
        input  lcd_rs,
        input  lcd_start,
        output lcd_done
    );
endinterface

// File: rtl/lcd_msg_rom.sv
// rtl/lcd_msg_rom.sv - combinational message text: row 0 carries the message title, lower rows a row label
module lcd_msg_rom
    import lcd_pkg::*;
#(
    parameter int NUM_MSGS = 8,
    parameter int MSW      = 3,
    parameter int CW       = 5
) (
    input  logic [MSW-1:0] msg,
    input  logic [1:0]     row,
    input  logic [CW-1:0]  col,
    output logic [7:0]     ch
);

    localparam logic [8*TITLE_LEN-1:0] TITLES [16] = '{
        "MESSAGE 00 TITLE", "MESSAGE 01 TITLE", "MESSAGE 02 TITLE", "MESSAGE 03 TITLE",
        "MESSAGE 04 TITLE", "MESSAGE 05 TITLE", "MESSAGE 06 TITLE", "MESSAGE 07 TITLE",
        "MESSAGE 08 TITLE", "MESSAGE 09 TITLE", "MESSAGE 10 TITLE", "MESSAGE 11 TITLE",
        "MESSAGE 12 TITLE", "MESSAGE 13 TITLE", "MESSAGE 14 TITLE", "MESSAGE 15 TITLE"
    };

    logic [3:0]             idx;
    logic [8*TITLE_LEN-1:0] title;

    always_comb begin
        idx   = 4'(msg);
        // First character sits in the top byte, so shifting left walks along the string.
        title = TITLES[idx] << (8 * int'(col));
        ch    = SPACE_CHAR;
        if (int'(msg) < NUM_MSGS) begin
            if (row == 2'd0) begin
                if (int'(col) < TITLE_LEN) begin
                    ch = title[8*TITLE_LEN-1 -: 8];
                end
            end else begin
                case (int'(col))
                    0:       ch = 8'h52;
                    1:       ch = 8'h4F;
                    2:       ch = 8'h57;
                    4:       ch = 8'h30 + 8'(row);
                    default: ch = SPACE_CHAR;
                endcase
            end
        end
    end

endmodule

// File: rtl/lcd_msg_sequencer.sv
// rtl/lcd_msg_sequencer.sv - walks init commands and message text out to the LCD controller one byte at a time
module lcd_msg_sequencer
    import lcd_pkg::*;
#(
    parameter int   NUM_MSGS   = 8,
    parameter int   ROWS       = 2,
    parameter int   COLS       = 16,
    parameter int   DLY_CYCLES = 262142,
    localparam int  MSW        = $clog2(NUM_MSGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [MSW-1:0]       msg_sel,
    input  logic                 refresh,
    output logic                 busy,
    output logic [MSW-1:0]       shown_msg,
    lcd_msg_sequencer_if.master  lcd
);

    localparam int SW = $clog2(INIT_STEPS + ROWS * (COLS + 1) + 1);
    localparam int CW = $clog2(COLS + 1);
    localparam int DW = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;

    localparam logic [SW-1:0] FIRST_DRAW = SW'(INIT_STEPS);
    localparam logic [SW-1:0] LAST_STEP  = SW'(INIT_STEPS + ROWS * (COLS + 1) - 1);
    localparam logic [CW-1:0] LAST_COL   = CW'(COLS);
    localparam logic [DW-1:0] DLY_LAST   = DW'(DLY_CYCLES - 1);

    seq_state_t     state_q, state_d;
    logic [SW-1:0]  step_q, step_d;
    logic [1:0]     row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic [MSW-1:0] msg_q, msg_d;
    logic [MSW-1:0] shown_q, shown_d;
    logic           pend_q, pend_d;
    logic [DW-1:0]  dly_q, dly_d;
    logic [7:0]     data_q, data_d;
    logic           rs_q, rs_d;
    logic           start_q, start_d;

    logic [7:0]     rom_ch;
    logic [7:0]     load_byte;
    logic           load_rs;
    logic           drawing;
    logic           last_step;

    // col 0 of each row slot is the row address command, so text column is col-1.
    lcd_msg_rom #(
        .NUM_MSGS (NUM_MSGS),
        .MSW      (MSW),
        .CW       (CW)
    ) u_rom (
        .msg (msg_q),
        .row (row_q),
        .col (col_q - CW'(1)),
        .ch  (rom_ch)
    );

    assign lcd.lcd_data  = data_q;
    assign lcd.lcd_rs    = rs_q;
    assign lcd.lcd_start = start_q;
    assign busy          = !(state_q == ST_IDLE && !pend_q);
    assign shown_msg     = shown_q;
    assign drawing       = (step_q >= FIRST_DRAW);
    assign last_step     = (step_q == LAST_STEP);

    always_comb begin
        load_byte = 8'h00;
        load_rs   = 1'b0;
        if (!drawing) begin
            load_byte = init_cmd(step_q[1:0]);
        end else if (col_q == '0) begin
            load_byte = row_addr(row_q);
        end else begin
            load_byte = rom_ch;
            load_rs   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_LOAD;
            step_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            msg_q   <= '0;
            shown_q <= '0;
            pend_q  <= 1'b0;
            dly_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            row_q   <= row_d;
            col_q   <= col_d;
            msg_q   <= msg_d;
            shown_q <= shown_d;
            pend_q  <= pend_d;
            dly_q   <= dly_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        row_d   = row_q;
        col_d   = col_q;
        msg_d   = msg_q;
        shown_d = shown_q;
        pend_d  = pend_q;
        dly_d   = dly_q;
        data_d  = data_q;
        rs_d    = rs_q;
        start_d = start_q;

        // A draw is never aborted; requests arriving mid-draw are remembered instead.
        if (state_q != ST_IDLE && (refresh || (drawing && msg_sel != msg_q))) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_q || refresh || msg_sel != shown_q) begin
                    pend_d  = 1'b0;
                    msg_d   = msg_sel;
                    step_d  = FIRST_DRAW;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                data_d  = load_byte;
                rs_d    = load_rs;
                start_d = 1'b1;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (lcd.lcd_done) begin
                    start_d = 1'b0;
                    dly_d   = '0;
                    state_d = ST_SETTLE;
                    if (last_step) begin
                        shown_d = msg_q;
                    end
                end
            end
            ST_SETTLE: begin
                if (dly_q == DLY_LAST) begin
                    state_d = ST_ADVANCE;
                end else begin
                    dly_d = dly_q + DW'(1);
                end
            end
            ST_ADVANCE: begin
                if (last_step) begin
                    state_d = ST_IDLE;
                end else begin
                    step_d  = step_q + SW'(1);
                    state_d = ST_LOAD;
                    if (step_q == FIRST_DRAW - SW'(1)) begin
                        msg_d = msg_sel;
                    end
                    if (drawing) begin
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = row_q + 2'd1;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// tb/tb_lcd_msg_sequencer.sv - randomized self-checking bench with a string-level model of the expected byte stream
module tb_lcd_msg_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [2:0] msg_sel_a, msg_sel_b, shown_a, shown_b;
    logic       refresh_a, refresh_b, busy_a, busy_b;
    logic       done_a = 1'b0;
    logic       done_b = 1'b0;

    lcd_msg_sequencer_if lcd_a();
    lcd_msg_sequencer_if lcd_b();
    assign lcd_a.lcd_done = done_a;
    assign lcd_b.lcd_done = done_b;

    lcd_msg_sequencer #(.NUM_MSGS(8), .ROWS(2), .COLS(16), .DLY_CYCLES(4)) dut_a (
        .clock(clock), .reset(reset), .msg_sel(msg_sel_a), .refresh(refresh_a),
        .busy(busy_a), .shown_msg(shown_a), .lcd(lcd_a)
    );

    lcd_msg_sequencer #(.NUM_MSGS(6), .ROWS(4), .COLS(20), .DLY_CYCLES(4)) dut_b (
        .clock(clock), .reset(reset), .msg_sel(msg_sel_b), .refresh(refresh_b),
        .busy(busy_b), .shown_msg(shown_b), .lcd(lcd_b)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] got_a[$];
    logic [8:0] got_b[$];
    logic [8:0] exp_q[$];

    bit hold_a = 1'b0;
    bit stray_a = 1'b0;
    bit stray_next_a = 1'b0;
    bit stray_now_a = 1'b0;
    int cnt_a = 0;
    int cnt_b = 0;

    // Controller model A: acks on the 3rd sampled cycle of lcd_start, can stall or inject stray acks.
    always @(negedge clock) begin
        if (reset) begin
            done_a = 1'b0; cnt_a = 0; stray_next_a = 1'b0; stray_now_a = 1'b0;
        end else if (done_a) begin
            done_a = 1'b0;
            if (stray_a && !stray_now_a) stray_next_a = 1'b1;
            stray_now_a = 1'b0;
        end else if (stray_next_a) begin
            stray_next_a = 1'b0; stray_now_a = 1'b1; done_a = 1'b1;
        end else if (lcd_a.lcd_start && !hold_a) begin
            cnt_a++;
            if (cnt_a == 3) begin
                cnt_a = 0; done_a = 1'b1;
                got_a.push_back({lcd_a.lcd_rs, lcd_a.lcd_data});
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            done_b = 1'b0; cnt_b = 0;
        end else if (done_b) begin
            done_b = 1'b0;
        end else if (lcd_b.lcd_start) begin
            cnt_b++;
            if (cnt_b == 3) begin
                cnt_b = 0; done_b = 1'b1;
                got_b.push_back({lcd_b.lcd_rs, lcd_b.lcd_data});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_char(input int m, input int r, input int c, input int nmsgs);
        string s;
        if (m >= nmsgs) return 8'h20;
        s = (r == 0) ? $sformatf("MESSAGE %02d TITLE", m) : $sformatf("ROW %0d", r);
        return (c < s.len()) ? s[c] : 8'h20;
    endfunction

    // HD44780 layout: odd rows at +0x40, rows 2/3 continue rows 0/1 at +20.
    function automatic logic [7:0] row_base(input int r);
        return 8'h80 + (((r % 2) == 1) ? 8'h40 : 8'h00) + ((r >= 2) ? 8'd20 : 8'd0);
    endfunction

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic push_draw(input int m, input int rows, input int cols, input int nmsgs);
        for (int r = 0; r < rows; r++) begin
            exp_q.push_back({1'b0, row_base(r)});
            for (int c = 0; c < cols; c++) exp_q.push_back({1'b1, exp_char(m, r, c, nmsgs)});
        end
    endtask

    task automatic check_stream(input string tag, input bit use_b);
        int n;
        n = use_b ? got_b.size() : got_a.size();
        check({tag, "_len"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [8:0] g;
            g = 9'h1FF;
            if (i < n) g = use_b ? got_b[i] : got_a[i];
            check($sformatf("%s_%0d", tag, i), g, exp_q[i]);
        end
        exp_q.delete();
        if (use_b) got_b.delete(); else got_a.delete();
    endtask

    task automatic wait_busy(input bit use_b, input logic lvl, input string tag);
        int n;
        n = 0;
        while (((use_b ? busy_b : busy_a) !== lvl) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check(tag, use_b ? busy_b : busy_a, lvl);
    endtask

    task automatic pulse_refresh_a();
        refresh_a = 1'b1;
        @(negedge clock);
        refresh_a = 1'b0;
    endtask

    logic [2:0] m1, m2, nxt;
    logic [7:0] snap_data;
    logic       snap_rs;
    bit         changed;
    int         guard;

    initial begin
        msg_sel_a = 3'($urandom_range(0, 7));
        msg_sel_b = 3'd6;
        refresh_a = 1'b0;
        refresh_b = 1'b0;
        reset     = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_start", lcd_a.lcd_start, 1'b0);
        check("rst_data", lcd_a.lcd_data, 8'h00);
        check("rst_rs", lcd_a.lcd_rs, 1'b0);
        check("rst_busy", busy_a, 1'b1);
        check("rst_shown", shown_a, 3'd0);
        check("rst_busy_b", busy_b, 1'b1);
        reset = 1'b0;

        push_init();
        push_draw(int'(msg_sel_a), 2, 16, 8);
        wait_busy(1'b0, 1'b0, "boot_idle");
        check_stream("boot", 1'b0);
        check("boot_shown", shown_a, msg_sel_a);

        push_init();
        push_draw(6, 4, 20, 6);
        wait_busy(1'b1, 1'b0, "blank_idle");
        check_stream("blank", 1'b1);
        check("blank_shown", shown_b, 3'd6);

        for (int it = 0; it < 4; it++) begin
            if (it < 3) begin
                do nxt = 3'($urandom_range(0, 7)); while (nxt == msg_sel_a);
                msg_sel_a = nxt;
            end else begin
                pulse_refresh_a();
            end
            push_draw(int'(msg_sel_a), 2, 16, 8);
            wait_busy(1'b0, 1'b1, $sformatf("sel%0d_start", it));
            wait_busy(1'b0, 1'b0, $sformatf("sel%0d_idle", it));
            check_stream($sformatf("sel%0d", it), 1'b0);
            check($sformatf("sel%0d_shown", it), shown_a, msg_sel_a);
        end

        do m1 = 3'($urandom_range(0, 7)); while (m1 == msg_sel_a);
        do m2 = 3'($urandom_range(0, 7)); while (m2 == m1);
        msg_sel_a = m1;
        guard = 0;
        while (got_a.size() < 11 && guard < 5000) begin @(negedge clock); guard++; end
        check("chg_reach", got_a.size() >= 11, 1'b1);
        msg_sel_a = m2;
        push_draw(int'(m1), 2, 16, 8);
        push_draw(int'(m2), 2, 16, 8);
        wait_busy(1'b0, 1'b0, "chg_idle");
        check_stream("chg", 1'b0);
        check("chg_shown", shown_a, m2);

        hold_a = 1'b1;
        pulse_refresh_a();
        guard = 0;
        while (lcd_a.lcd_start !== 1'b1 && guard < 100) begin @(negedge clock); guard++; end
        check("hold_req", lcd_a.lcd_start, 1'b1);
        snap_data = lcd_a.lcd_data;
        snap_rs   = lcd_a.lcd_rs;
        changed   = 1'b0;
        repeat (100) begin
            @(negedge clock);
            if (lcd_a.lcd_start !== 1'b1 || lcd_a.lcd_data !== snap_data || lcd_a.lcd_rs !== snap_rs)
                changed = 1'b1;
        end
        check("hold_stable", changed, 1'b0);
        check("hold_byte", {snap_rs, snap_data}, {1'b0, 8'h80});
        stray_a = 1'b1;
        hold_a  = 1'b0;
        push_draw(int'(msg_sel_a), 2, 16, 8);
        wait_busy(1'b0, 1'b0, "stray_idle");
        stray_a = 1'b0;
        check_stream("stray", 1'b0);
        check("stray_shown", shown_a, msg_sel_a);

        pulse_refresh_a();
        guard = 0;
        while (got_a.size() < 7 && guard < 5000) begin @(negedge clock); guard++; end
        hold_a = 1'b1;
        guard = 0;
        while (lcd_a.lcd_start !== 1'b1 && guard < 100) begin @(negedge clock); guard++; end
        repeat (2) @(negedge clock);
        check("mid_start", lcd_a.lcd_start, 1'b1);
        check("mid_byte", {lcd_a.lcd_rs, lcd_a.lcd_data}, {1'b1, exp_char(int'(msg_sel_a), 0, 6, 8)});
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_start", lcd_a.lcd_start, 1'b0);
        check("mid_rst_data", lcd_a.lcd_data, 8'h00);
        check("mid_rst_busy", busy_a, 1'b1);
        check("mid_rst_shown", shown_a, 3'd0);
        @(negedge clock);
        got_a.delete();
        reset  = 1'b0;
        hold_a = 1'b0;
        push_init();
        push_draw(int'(msg_sel_a), 2, 16, 8);
        wait_busy(1'b0, 1'b0, "rerun_idle");
        check_stream("rerun", 1'b0);
        check("rerun_shown", shown_a, msg_sel_a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_msg_sequencer.md
LCD_MSG_SEQUENCER -- requirements
Module: lcd_msg_sequencer

Interface
REQ-001 SHALL have parameter NUM_MSGS, default 8, number of selectable screen messages (2..16).
REQ-002 SHALL have parameter ROWS, default 2, display rows (1..4).
REQ-003 SHALL have parameter COLS, default 16, characters per row (8..40).
REQ-004 SHALL have parameter DLY_CYCLES, default 262142, settle cycles after each controller done (>=1).
REQ-005 SHALL have ports: clock  in  1  system clock; reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port msg_sel  in  MSW=clog2(NUM_MSGS)  requested message index.
REQ-007 SHALL have port refresh  in  1  one-cycle pulse forcing a redraw of msg_sel.
REQ-008 SHALL have ports lcd_data  out  8  byte to controller; lcd_rs  out  1  0=command, 1=character.
REQ-009 SHALL have ports lcd_start  out  1  transfer request; lcd_done  in  1  controller completion pulse.
REQ-010 SHALL have ports busy  out  1  sequence in progress; shown_msg  out  MSW  last fully drawn message.

Function
REQ-011 SHALL, after reset, send init commands 0x38, 0x0C, 0x01, 0x06 (rs=0) once, then draw msg_sel.
REQ-012 SHALL draw a message as: per row r, command row address (0x80, 0xC0, 0x94, 0xD4 for r=0..3), then COLS characters rs=1.
REQ-013 SHALL use states IDLE, LOAD, REQ, WAIT_DONE, SETTLE, ADVANCE; LOAD latches byte+rs, REQ raises lcd_start.
REQ-014 SHALL hold lcd_start high and lcd_data/lcd_rs stable from REQ until the cycle lcd_done is sampled high, then drop lcd_start the next cycle.
REQ-015 SHALL wait exactly DLY_CYCLES clock cycles in SETTLE before ADVANCE increments the step index.
REQ-016 SHALL start a redraw from IDLE when refresh pulses or msg_sel differs from shown_msg; latched message fixed for the whole draw.
REQ-017 SHALL, if refresh or msg_sel change occurs mid-draw, set a pending flag and redraw immediately after the current draw completes (no abort).
REQ-018 SHALL update shown_msg in the cycle the last character is acknowledged; busy low only in IDLE with no pending request.
REQ-019 SHALL map msg_sel >= NUM_MSGS to an all-space (0x20) message.
REQ-020 SHALL ignore lcd_done outside WAIT_DONE.
REQ-021 SHALL use step counter width clog2(4+ROWS*(COLS+1)+1); no wrap within a draw.

Reset
REQ-022 SHALL on reset force: state LOAD of init step 0, lcd_start=0, lcd_data=0x00, lcd_rs=0, busy=1, shown_msg=0, pending=0, delay counter=0.
REQ-023 SHALL, on reset asserted mid-transfer, drop lcd_start next edge and restart the full init sequence.

Structure
REQ-024 SHALL place init command bytes, row base addresses and state encoding in shared package lcd_pkg.
REQ-025 SHALL use one sub-module lcd_msg_rom (combinational: msg, row, col -> ASCII byte) holding message text.
REQ-026 SHALL instantiate existing LCD controller outside this block; this block only drives its host side.

Verification
REQ-027 Reset, controller model acks after 3 cycles, DLY_CYCLES=4 -> bytes 0x38,0x0C,0x01,0x06,0x80, 16 chars, 0xC0, 16 chars in order; busy falls after 38th ack.
REQ-028 Idle with shown_msg=2, set msg_sel=5 -> exactly 34 transfers of msg 5, shown_msg=5, no init commands resent.
REQ-029 msg_sel 1->3 at 10th character of draw -> msg 1 completes, then msg 3 drawn, shown_msg ends 3.
REQ-030 lcd_done held low 100 cycles -> lcd_start, lcd_data, lcd_rs stay constant; stray lcd_done in SETTLE -> no extra step.
REQ-031 reset asserted during WAIT_DONE of char 7 -> lcd_start 0 next cycle, sequence restarts at 0x38.
REQ-032 ROWS=4, COLS=20, msg_sel=NUM_MSGS -> row commands 0x80,0xC0,0x94,0xD4, all 80 characters 0x20.
